minesweeper_ctrl: RTL
=====================

// Module: minesweeper_ctrl
// PURPOSE
//   Second-generation gameplay controller for the Nexys-A7 SVGA minesweeper. Takes button
//   events and the mined field from field_filler. Owns cursor, per-cell visibility, flag
//   budget, open-cell counter and win/lose detection. Adds raster-sweep flood fill of empty
//   regions, mine reveal on loss and restart. Feeds the SVGA renderer.
// PARAMETERS
//   MAX_CELL_WIDTH   30  max columns; CELL_X_WIDTH = $clog2(MAX_CELL_WIDTH)
//   MAX_CELL_HEIGHT  16  max rows;    CELL_Y_WIDTH = $clog2(MAX_CELL_HEIGHT)
//   MINES_W          $clog2(MAX_CELL_WIDTH*MAX_CELL_HEIGHT/4)  width of mine/flag counts
// PORTS
//   clk             in   1      single clock
//   rst             in   1      synchronous, active-low reset
//   button_c_short  in   1      1-cycle pulse: start / flag toggle / restart
//   button_c_long   in   1      1-cycle pulse: open cell under cursor
//   button_u/d/l/r  in   1 each 1-cycle pulses: cursor move
//   field_width_i   in   CELL_X_WIDTH  requested width
//   field_height_i  in   CELL_Y_WIDTH  requested height
//   mines_count_i   in   MINES_W       requested mines
//   fill_start_o    out  1      1-cycle pulse to field_filler
//   fill_done_i     in   1      field_filler finished (level or pulse)
//   cells_state_i   in   4 x [W][H]  0..8 = neighbour mine count, 10 = mine
//   cells_vis_o     out  2 x [W][H]  0 closed, 1 open, 2 flag
//   player_x_o      out  CELL_X_WIDTH  cursor column
//   player_y_o      out  CELL_Y_WIDTH  cursor row
//   flags_left_o    out  MINES_W   mines_count minus flags placed
//   game_state_o    out  4     encoded FSM state (below)
//   busy_o          out  1     high in FIELD_GEN, FLOOD, REVEAL
// BEHAVIOUR
//   Reset (rst==0 at posedge):
//     - state GAME_START, all cells closed, cursor (0,0), flags_left 0, fill_start_o 0.
//   States (game_state_o): GAME_START=0, FIELD_GEN=1, IDLE=2, CURSOR_MOVE=3, OPEN_CELL=4,
//     FLAG_PUT=5, FLOOD=6, REVEAL=7, GAME_WIN=8, GAME_LOSE=9.
//   GAME_START, on c_short:
//     - latch width/height/mines; width or height of 0 or > MAX is clamped to MAX.
//     - mines 0 or >= W*H is clamped to W*H/4.
//     - clear vis, flags_left<=mines, open_cnt<=0; pulse fill_start_o next cycle -> FIELD_GEN.
//   FIELD_GEN: wait fill_done_i -> IDLE; cursor <= (W>>1, H>>1) on exit.
//   IDLE: event priority move > c_long > c_short; other events same cycle dropped.
//     Events arriving outside IDLE/GAME_START/WIN/LOSE are dropped.
//   CURSOR_MOVE (1 cycle) -> IDLE:
//     - l beats r, d beats u; x and y update together.
//     - l: x==0 ? W-1 : x-1.  r: x==W-1 ? 0 : x+1.
//     - d: y==0 ? H-1 : y-1.  u: y==H-1 ? 0 : y+1.
//   FLAG_PUT (1 cycle) -> IDLE:
//     - closed -> flag only if flags_left>0 (then flags_left-1).
//     - flag -> closed (flags_left+1); open cell unchanged.
//   OPEN_CELL (1 cycle), acting on the cell under the cursor:
//     - flag or open cell: no-op -> IDLE.
//     - mine (10): open it -> REVEAL.
//     - 0: open, open_cnt+1 -> FLOOD.
//     - 1..8: open, open_cnt+1 -> IDLE, or GAME_WIN if open_cnt+1 == W*H-mines.
//   FLOOD: raster sweep over x<W, y<H, one cell per cycle.
//     - closed non-mine cell with any open 8-neighbour of state 0: open it, open_cnt+1.
//     - flags are never opened by flood.
//     - sweep repeats until a full pass opens nothing.
//     - then GAME_WIN if open_cnt==W*H-mines, else IDLE.
//   REVEAL: one sweep opening every mine cell that is not flagged -> GAME_LOSE.
//   GAME_WIN / GAME_LOSE: vis frozen; c_short -> GAME_START (vis cleared there).
//   Cells outside W x H are never modified and stay closed.
//   open_cnt width is $clog2(MAX_W*MAX_H+1).
// TESTING
//   1. Reset mid-FLOOD -> next cycle state 0, all vis closed, busy_o 0.
//   2. W=9, H=9; cursor (0,4); press l -> x=8. Press r at x=8 -> x=0.
//      Press l+r in same cycle -> x-1.
//   3. mines=10; flag 10 cells -> flags_left 0; 11th flag ignored.
//      Unflag one -> flags_left 1.
//   4. Field with a single mine at (8,8); open (0,0) (state 0):
//      - flood opens all 80 safe cells;
//      - GAME_WIN within 3 full sweeps (<=243 cycles after FLOOD entry).
//   5. Open a mine at (3,3) with (5,5) mined and flagged:
//      - (3,3) open; other unflagged mines open; (5,5) stays flag; state 9.
//   6. c_long on a flagged cell and on an open cell -> vis and open_cnt unchanged,
//      back to IDLE in 1 cycle.

Source files
------------

// File: rtl/minesweeper_ctrl.sv
// Gameplay controller for the SVGA minesweeper: cursor, per-cell visibility, flag budget,
// flood fill of empty regions, mine reveal on loss and win/lose tracking.
module minesweeper_ctrl #(
  parameter int MAX_CELL_WIDTH  = 30,
  parameter int MAX_CELL_HEIGHT = 16,
  parameter int CELL_X_WIDTH    = $clog2(MAX_CELL_WIDTH),
  parameter int CELL_Y_WIDTH    = $clog2(MAX_CELL_HEIGHT),
  parameter int MINES_W         = $clog2(MAX_CELL_WIDTH * MAX_CELL_HEIGHT / 4)
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                button_c_short,
  input  logic                                                button_c_long,
  input  logic                                                button_u,
  input  logic                                                button_d,
  input  logic                                                button_l,
  input  logic                                                button_r,
  input  logic [CELL_X_WIDTH-1:0]                             field_width_i,
  input  logic [CELL_Y_WIDTH-1:0]                             field_height_i,
  input  logic [MINES_W-1:0]                                  mines_count_i,
  output logic                                                fill_start_o,
  input  logic                                                fill_done_i,
  input  logic [MAX_CELL_WIDTH-1:0][MAX_CELL_HEIGHT-1:0][3:0] cells_state_i,
  output logic [MAX_CELL_WIDTH-1:0][MAX_CELL_HEIGHT-1:0][1:0] cells_vis_o,
  output logic [CELL_X_WIDTH-1:0]                             player_x_o,
  output logic [CELL_Y_WIDTH-1:0]                             player_y_o,
  output logic [MINES_W-1:0]                                  flags_left_o,
  output logic [3:0]                                          game_state_o,
  output logic                                                busy_o
);

  localparam int WX    = $clog2(MAX_CELL_WIDTH + 1);
  localparam int WY    = $clog2(MAX_CELL_HEIGHT + 1);
  localparam int CNT_W = $clog2(MAX_CELL_WIDTH * MAX_CELL_HEIGHT + 1);
  localparam int NXW   = WX + 2;
  localparam int NYW   = WY + 2;

  localparam logic [3:0] MINE       = 4'd10;
  localparam logic [1:0] VIS_CLOSED = 2'd0;
  localparam logic [1:0] VIS_OPEN   = 2'd1;
  localparam logic [1:0] VIS_FLAG   = 2'd2;

  localparam int MV_U = 0;
  localparam int MV_D = 1;
  localparam int MV_L = 2;
  localparam int MV_R = 3;

  typedef enum logic [3:0] {
    GAME_START  = 4'd0,
    FIELD_GEN   = 4'd1,
    IDLE        = 4'd2,
    CURSOR_MOVE = 4'd3,
    OPEN_CELL   = 4'd4,
    FLAG_PUT    = 4'd5,
    FLOOD       = 4'd6,
    REVEAL      = 4'd7,
    GAME_WIN    = 4'd8,
    GAME_LOSE   = 4'd9
  } state_e;

  state_e state_q, state_d;

  logic [MAX_CELL_WIDTH-1:0][MAX_CELL_HEIGHT-1:0][1:0] vis_q, vis_d;
  logic [WX-1:0]           width_q, width_d;
  logic [WY-1:0]           height_q, height_d;
  logic [CNT_W-1:0]        target_q, target_d;
  logic [CNT_W-1:0]        open_cnt_q, open_cnt_d;
  logic [MINES_W-1:0]      flags_left_q, flags_left_d;
  logic [CELL_X_WIDTH-1:0] player_x_q, player_x_d;
  logic [CELL_Y_WIDTH-1:0] player_y_q, player_y_d;
  logic [CELL_X_WIDTH-1:0] scan_x_q, scan_x_d;
  logic [CELL_Y_WIDTH-1:0] scan_y_q, scan_y_d;
  logic                    pass_opened_q, pass_opened_d;
  logic [3:0]              mv_q, mv_d;
  logic                    fill_start_q, fill_start_d;

  logic [WX-1:0]           width_c;
  logic [WY-1:0]           height_c;
  logic [CNT_W-1:0]        area_c;
  logic [MINES_W-1:0]      mines_c;
  logic [CNT_W-1:0]        target_c;
  logic [CELL_X_WIDTH-1:0] w_last;
  logic [CELL_Y_WIDTH-1:0] h_last;
  logic                    scan_last;
  logic [1:0]              cur_vis, scan_vis;
  logic [3:0]              cur_cell, scan_cell;
  logic                    any_move;
  logic                    fill_ack;
  logic                    nbr_zero_open;
  logic                    flood_open;
  logic                    flood_done;
  logic signed [NXW-1:0]   nb_x;
  logic signed [NYW-1:0]   nb_y;

  // Out-of-range or zero geometry falls back to the full board.
  always_comb begin
    width_c  = (field_width_i == '0 || WX'(field_width_i) > WX'(MAX_CELL_WIDTH))
               ? WX'(MAX_CELL_WIDTH) : WX'(field_width_i);
    height_c = (field_height_i == '0 || WY'(field_height_i) > WY'(MAX_CELL_HEIGHT))
               ? WY'(MAX_CELL_HEIGHT) : WY'(field_height_i);
    area_c   = CNT_W'(width_c) * CNT_W'(height_c);
    mines_c  = (mines_count_i == '0 || CNT_W'(mines_count_i) >= area_c)
               ? MINES_W'(area_c >> 2) : mines_count_i;
    target_c = area_c - CNT_W'(mines_c);
  end

  assign w_last    = CELL_X_WIDTH'(width_q - WX'(1));
  assign h_last    = CELL_Y_WIDTH'(height_q - WY'(1));
  assign scan_last = (scan_x_q == w_last) && (scan_y_q == h_last);
  assign cur_vis   = vis_q[player_x_q][player_y_q];
  assign cur_cell  = cells_state_i[player_x_q][player_y_q];
  assign scan_vis  = vis_q[scan_x_q][scan_y_q];
  assign scan_cell = cells_state_i[scan_x_q][scan_y_q];
  assign any_move  = button_u | button_d | button_l | button_r;
  // A level-style done left high from the previous game must not end the new fill early.
  assign fill_ack  = fill_done_i & ~fill_start_q;

  always_comb begin
    nbr_zero_open = 1'b0;
    nb_x = '0;
    nb_y = '0;
    for (int dx = -1; dx <= 1; dx++) begin
      for (int dy = -1; dy <= 1; dy++) begin
        nb_x = $signed(NXW'(scan_x_q)) + NXW'(dx);
        nb_y = $signed(NYW'(scan_y_q)) + NYW'(dy);
        if ((dx != 0 || dy != 0) && !nb_x[NXW-1] && !nb_y[NYW-1] &&
            nb_x < $signed(NXW'(width_q)) && nb_y < $signed(NYW'(height_q))) begin
          if (vis_q[nb_x[CELL_X_WIDTH-1:0]][nb_y[CELL_Y_WIDTH-1:0]] == VIS_OPEN &&
              cells_state_i[nb_x[CELL_X_WIDTH-1:0]][nb_y[CELL_Y_WIDTH-1:0]] == 4'd0)
            nbr_zero_open = 1'b1;
        end
      end
    end
  end

  assign flood_open = (scan_vis == VIS_CLOSED) && (scan_cell != MINE) && nbr_zero_open;
  assign flood_done = scan_last && !pass_opened_q && !flood_open;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= GAME_START;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      GAME_START:  if (button_c_short) state_d = FIELD_GEN;
      FIELD_GEN:   if (fill_ack) state_d = IDLE;
      IDLE: begin
        if (any_move)            state_d = CURSOR_MOVE;
        else if (button_c_long)  state_d = OPEN_CELL;
        else if (button_c_short) state_d = FLAG_PUT;
      end
      CURSOR_MOVE: state_d = IDLE;
      FLAG_PUT:    state_d = IDLE;
      OPEN_CELL: begin
        if (cur_vis != VIS_CLOSED)                      state_d = IDLE;
        else if (cur_cell == MINE)                      state_d = REVEAL;
        else if (cur_cell == 4'd0)                      state_d = FLOOD;
        else if ((open_cnt_q + CNT_W'(1)) == target_q)  state_d = GAME_WIN;
        else                                            state_d = IDLE;
      end
      FLOOD:       if (flood_done) state_d = (open_cnt_q == target_q) ? GAME_WIN : IDLE;
      REVEAL:      if (scan_last) state_d = GAME_LOSE;
      GAME_WIN,
      GAME_LOSE:   if (button_c_short) state_d = GAME_START;
      default:     state_d = GAME_START;
    endcase
  end

  always_comb begin
    busy_o = 1'b0;
    case (state_q)
      FIELD_GEN, FLOOD, REVEAL: busy_o = 1'b1;
      default:                  busy_o = 1'b0;
    endcase
  end

  always_comb begin
    vis_d         = vis_q;
    width_d       = width_q;
    height_d      = height_q;
    target_d      = target_q;
    open_cnt_d    = open_cnt_q;
    flags_left_d  = flags_left_q;
    player_x_d    = player_x_q;
    player_y_d    = player_y_q;
    scan_x_d      = scan_x_q;
    scan_y_d      = scan_y_q;
    pass_opened_d = pass_opened_q;
    mv_d          = mv_q;
    fill_start_d  = 1'b0;

    case (state_q)
      GAME_START: begin
        if (button_c_short) begin
          width_d      = width_c;
          height_d     = height_c;
          target_d     = target_c;
          flags_left_d = mines_c;
          open_cnt_d   = '0;
          vis_d        = '0;
          fill_start_d = 1'b1;
        end
      end
      FIELD_GEN: begin
        if (fill_ack) begin
          player_x_d = CELL_X_WIDTH'(width_q >> 1);
          player_y_d = CELL_Y_WIDTH'(height_q >> 1);
        end
      end
      IDLE: begin
        mv_d = {button_r, button_l, button_d, button_u};
      end
      CURSOR_MOVE: begin
        if (mv_q[MV_L])      player_x_d = (player_x_q == '0) ? w_last : player_x_q - 1'b1;
        else if (mv_q[MV_R]) player_x_d = (player_x_q == w_last) ? '0 : player_x_q + 1'b1;
        if (mv_q[MV_D])      player_y_d = (player_y_q == '0) ? h_last : player_y_q - 1'b1;
        else if (mv_q[MV_U]) player_y_d = (player_y_q == h_last) ? '0 : player_y_q + 1'b1;
      end
      FLAG_PUT: begin
        if (cur_vis == VIS_CLOSED && flags_left_q != '0) begin
          vis_d[player_x_q][player_y_q] = VIS_FLAG;
          flags_left_d = flags_left_q - 1'b1;
        end else if (cur_vis == VIS_FLAG) begin
          vis_d[player_x_q][player_y_q] = VIS_CLOSED;
          flags_left_d = flags_left_q + 1'b1;
        end
      end
      OPEN_CELL: begin
        scan_x_d      = '0;
        scan_y_d      = '0;
        pass_opened_d = 1'b0;
        if (cur_vis == VIS_CLOSED) begin
          vis_d[player_x_q][player_y_q] = VIS_OPEN;
          if (cur_cell != MINE) open_cnt_d = open_cnt_q + 1'b1;
        end
      end
      FLOOD, REVEAL: begin
        if (state_q == FLOOD && flood_open) begin
          vis_d[scan_x_q][scan_y_q] = VIS_OPEN;
          open_cnt_d    = open_cnt_q + 1'b1;
          pass_opened_d = 1'b1;
        end
        if (state_q == REVEAL && scan_vis == VIS_CLOSED && scan_cell == MINE)
          vis_d[scan_x_q][scan_y_q] = VIS_OPEN;
        // Raster order, x fastest; wrap to a fresh pass at the last cell.
        if (scan_last) begin
          scan_x_d      = '0;
          scan_y_d      = '0;
          pass_opened_d = 1'b0;
        end else if (scan_x_q == w_last) begin
          scan_x_d = '0;
          scan_y_d = scan_y_q + 1'b1;
        end else begin
          scan_x_d = scan_x_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      vis_q         <= '0;
      width_q       <= '0;
      height_q      <= '0;
      target_q      <= '0;
      open_cnt_q    <= '0;
      flags_left_q  <= '0;
      player_x_q    <= '0;
      player_y_q    <= '0;
      scan_x_q      <= '0;
      scan_y_q      <= '0;
      pass_opened_q <= 1'b0;
      mv_q          <= '0;
      fill_start_q  <= 1'b0;
    end else begin
      vis_q         <= vis_d;
      width_q       <= width_d;
      height_q      <= height_d;
      target_q      <= target_d;
      open_cnt_q    <= open_cnt_d;
      flags_left_q  <= flags_left_d;
      player_x_q    <= player_x_d;
      player_y_q    <= player_y_d;
      scan_x_q      <= scan_x_d;
      scan_y_q      <= scan_y_d;
      pass_opened_q <= pass_opened_d;
      mv_q          <= mv_d;
      fill_start_q  <= fill_start_d;
    end
  end

  assign cells_vis_o  = vis_q;
  assign player_x_o   = player_x_q;
  assign player_y_o   = player_y_q;
  assign flags_left_o = flags_left_q;
  assign game_state_o = state_q;
  assign fill_start_o = fill_start_q;

endmodule
